// File: rtl/ins_line_cache.sv
// rtl/ins_line_cache.sv - direct-mapped instruction line cache with word-serial refill
// Lookup is combinational in IDLE; a miss refills the whole line one word per MemAck in FILL.
module ins_line_cache #(
   parameter int               dataW        = 32,
   parameter int               Lines        = 8,
   parameter int               WordsPerLine = 4,
   parameter logic [dataW-1:0] NopIns       = 32'h00000013
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [dataW-1:0] ProgAddr,
   input  logic             Flush,
   output logic [dataW-1:0] OutputIns,
   output logic             InsValid,
   output logic             InsCacheStall,
   output logic             Misaligned,
   output logic             MemReq,
   output logic [dataW-1:0] MemAddr,
   input  logic             MemAck,
   input  logic [dataW-1:0] MemData,
   output logic [31:0]      HitCount,
   output logic [31:0]      MissCount
);

   localparam int WB  = $clog2(WordsPerLine);
   localparam int IB  = $clog2(Lines);
   localparam int OFF = WB + 2;
   localparam int TB  = dataW - OFF - IB;

   typedef enum logic {IDLE, FILL} state_t;

   state_t state, state_nxt;

   logic [dataW-1:0] data_mem [Lines*WordsPerLine];
   logic [TB-1:0]    tag_mem  [Lines];
   logic [Lines-1:0] valid;

   logic [WB-1:0]    cnt;
   logic [dataW-1:0] base;
   logic [IB-1:0]    fill_idx;
   logic [TB-1:0]    fill_tag;
   logic             flush_pend;

   logic [WB-1:0]    word_sel;
   logic [IB-1:0]    idx;
   logic [TB-1:0]    tag;
   logic             hit;
   logic             last;
   logic             flush_at_done;

   assign word_sel      = ProgAddr[2 +: WB];
   assign idx           = ProgAddr[OFF +: IB];
   assign tag           = ProgAddr[dataW-1 -: TB];
   assign Misaligned    = |ProgAddr[1:0];
   assign hit           = (state == IDLE) && valid[idx] && (tag_mem[idx] == tag) && !Misaligned;
   assign last          = (cnt == WB'(WordsPerLine - 1));
   assign flush_at_done = flush_pend || Flush;
   assign MemAddr       = base + dataW'({cnt, 2'b00});

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      OutputIns     = NopIns;
      InsValid      = 1'b0;
      InsCacheStall = 1'b0;
      MemReq        = 1'b0;
      case (state)
         IDLE: begin
            if (hit) begin
               OutputIns = data_mem[{idx, word_sel}];
               InsValid  = 1'b1;
            end else if (!Misaligned) begin
               InsCacheStall = 1'b1;
               state_nxt     = FILL;
            end
         end
         FILL: begin
            MemReq        = 1'b1;
            InsCacheStall = 1'b1;
            if (MemAck && last) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      // Reset forces the post-reset view even while a fill is being aborted.
      if (reset) begin
         OutputIns     = NopIns;
         InsValid      = 1'b0;
         MemReq        = 1'b0;
         InsCacheStall = !Misaligned;
         state_nxt     = IDLE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid      <= '0;
         cnt        <= '0;
         flush_pend <= 1'b0;
         HitCount   <= '0;
         MissCount  <= '0;
      end else if (state == IDLE) begin
         if (Flush) begin
            valid <= '0;
         end
         if (hit && HitCount != 32'hFFFF_FFFF) begin
            HitCount <= HitCount + 32'd1;
         end
         if (!hit && !Misaligned) begin
            base     <= {ProgAddr[dataW-1:OFF], OFF'(0)};
            fill_idx <= idx;
            fill_tag <= tag;
            cnt      <= '0;
            if (MissCount != 32'hFFFF_FFFF) begin
               MissCount <= MissCount + 32'd1;
            end
         end
      end else begin
         if (Flush) begin
            flush_pend <= 1'b1;
         end
         if (MemAck) begin
            cnt <= cnt + WB'(1);
            if (last) begin
               flush_pend <= 1'b0;
               if (flush_at_done) begin
                  valid <= '0;
               end else begin
                  valid[fill_idx] <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && state == FILL && MemAck) begin
         data_mem[{fill_idx, cnt}] <= MemData;
         if (last) begin
            tag_mem[fill_idx] <= fill_tag;
         end
      end
   end

endmodule

// File: tb/tb_ins_line_cache.sv
// tb/tb_ins_line_cache.sv - directed bench for ins_line_cache
// Refill memory returns the requested address as data.
module tb_ins_line_cache;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ProgAddr = '0;
   logic        Flush = 1'b0;
   logic [31:0] OutputIns;
   logic        InsValid;
   logic        InsCacheStall;
   logic        Misaligned;
   logic        MemReq;
   logic [31:0] MemAddr;
   logic        MemAck = 1'b0;
   logic [31:0] MemData;
   logic [31:0] HitCount;
   logic [31:0] MissCount;

   int n_cmp = 0;
   int n_bad = 0;

   ins_line_cache dut (
      .clock(clock), .reset(reset), .ProgAddr(ProgAddr), .Flush(Flush),
      .OutputIns(OutputIns), .InsValid(InsValid), .InsCacheStall(InsCacheStall),
      .Misaligned(Misaligned), .MemReq(MemReq), .MemAddr(MemAddr),
      .MemAck(MemAck), .MemData(MemData), .HitCount(HitCount), .MissCount(MissCount)
   );

   always #5 clock = ~clock;
   assign MemData = MemAddr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic fill4(input logic [31:0] b);
      for (int k = 0; k < 4; k++) begin
         tick();
         #1;
         chk("fill_req", {31'd0, MemReq}, 32'd1);
         chk("fill_addr", MemAddr, b + 32'(4 * k));
         chk("fill_stall", {31'd0, InsCacheStall}, 32'd1);
      end
   endtask

   initial begin
      reset = 1'b1; ProgAddr = 32'h0; MemAck = 1'b1;
      tick(); tick(); #1;
      chk("rst_req", {31'd0, MemReq}, 32'd0);
      chk("rst_valid", {31'd0, InsValid}, 32'd0);
      chk("rst_ins", OutputIns, NOP);
      chk("rst_stall", {31'd0, InsCacheStall}, 32'd1);
      chk("rst_hits", HitCount, 32'd0);
      chk("rst_miss", MissCount, 32'd0);

      reset = 1'b0; #1;
      chk("c0_stall", {31'd0, InsCacheStall}, 32'd1);
      chk("c0_valid", {31'd0, InsValid}, 32'd0);
      chk("c0_req", {31'd0, MemReq}, 32'd0);
      fill4(32'h0);
      tick(); #1;
      chk("c5_valid", {31'd0, InsValid}, 32'd1);
      chk("c5_ins", OutputIns, 32'h0);
      chk("c5_stall", {31'd0, InsCacheStall}, 32'd0);
      chk("c5_miss", MissCount, 32'd1);
      chk("c5_hits", HitCount, 32'd0);

      for (int i = 1; i <= 3; i++) begin
         tick(); ProgAddr = 32'(4 * i); #1;
         chk("seq_valid", {31'd0, InsValid}, 32'd1);
         chk("seq_ins", OutputIns, 32'(4 * i));
         chk("seq_stall", {31'd0, InsCacheStall}, 32'd0);
         chk("seq_req", {31'd0, MemReq}, 32'd0);
         chk("seq_hits", HitCount, 32'(i));
      end

      tick(); ProgAddr = 32'h80; #1;
      chk("conf_hits", HitCount, 32'd4);
      chk("conf_stall", {31'd0, InsCacheStall}, 32'd1);
      fill4(32'h80);
      tick(); #1;
      chk("conf_ins", OutputIns, 32'h80);
      chk("conf_valid", {31'd0, InsValid}, 32'd1);
      chk("conf_miss2", MissCount, 32'd2);
      tick(); ProgAddr = 32'h0; #1;
      chk("evict_stall", {31'd0, InsCacheStall}, 32'd1);
      fill4(32'h0);
      tick(); #1;
      chk("evict_ins", OutputIns, 32'h0);
      chk("conf_miss3", MissCount, 32'd3);

      tick(); ProgAddr = 32'h10; MemAck = 1'b0; #1;
      chk("slow_stall", {31'd0, InsCacheStall}, 32'd1);
      for (int c = 1; c <= 12; c++) begin
         tick(); MemAck = (c % 3 == 0); ProgAddr = 32'h204; #1;
         chk("slow_req", {31'd0, MemReq}, 32'd1);
         chk("slow_addr", MemAddr, 32'h10 + 32'(4 * ((c - 1) / 3)));
      end
      tick(); MemAck = 1'b0; ProgAddr = 32'h10; #1;
      chk("slow_valid", {31'd0, InsValid}, 32'd1);
      chk("slow_ins0", OutputIns, 32'h10);
      chk("slow_miss", MissCount, 32'd4);
      tick(); ProgAddr = 32'h1C; MemAck = 1'b1; #1;
      chk("slow_ins3", OutputIns, 32'h1C);
      chk("idle_ack_req", {31'd0, MemReq}, 32'd0);

      tick(); ProgAddr = 32'h20; #1;
      chk("fl_stall", {31'd0, InsCacheStall}, 32'd1);
      tick();
      tick(); Flush = 1'b1; #1;
      chk("fl_req", {31'd0, MemReq}, 32'd1);
      tick(); Flush = 1'b0;
      tick();
      tick(); ProgAddr = 32'h0; #1;
      chk("fl_old_gone", {31'd0, InsCacheStall}, 32'd1);
      ProgAddr = 32'h20; #1;
      chk("fl_new_gone", {31'd0, InsCacheStall}, 32'd1);
      chk("fl_new_valid", {31'd0, InsValid}, 32'd0);
      chk("fl_miss", MissCount, 32'd5);
      fill4(32'h20);
      tick(); #1;
      chk("refill_ins", OutputIns, 32'h20);
      chk("refill_miss", MissCount, 32'd6);
      chk("refill_hits", HitCount, 32'd8);
      Flush = 1'b1; #1;
      chk("flidle_old", {31'd0, InsValid}, 32'd1);

      tick(); Flush = 1'b0; ProgAddr = 32'h6; #1;
      chk("mis_flag", {31'd0, Misaligned}, 32'd1);
      chk("mis_valid", {31'd0, InsValid}, 32'd0);
      chk("mis_stall", {31'd0, InsCacheStall}, 32'd0);
      chk("mis_req", {31'd0, MemReq}, 32'd0);
      chk("mis_hits", HitCount, 32'd9);
      chk("mis_miss", MissCount, 32'd6);
      tick(); #1;
      chk("mis_hits2", HitCount, 32'd9);
      chk("mis_miss2", MissCount, 32'd6);
      chk("mis_req2", {31'd0, MemReq}, 32'd0);
      ProgAddr = 32'h20; #1;
      chk("flidle_gone", {31'd0, InsCacheStall}, 32'd1);

      tick(); #1;
      chk("ab_req1", {31'd0, MemReq}, 32'd1);
      tick(); reset = 1'b1; #1;
      chk("ab_rst_req", {31'd0, MemReq}, 32'd0);
      tick(); reset = 1'b0; #1;
      chk("ab_req_after", {31'd0, MemReq}, 32'd0);
      chk("ab_line_inv", {31'd0, InsCacheStall}, 32'd1);
      chk("ab_valid", {31'd0, InsValid}, 32'd0);
      chk("ab_miss", MissCount, 32'd0);
      chk("ab_hits", HitCount, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ins_line_cache.md
INS_LINE_CACHE -- requirements
Module: ins_line_cache

Interface
REQ-001 SHALL have parameter dataW, default 32: instruction and address width.
REQ-002 SHALL have parameter Lines, default 8: cache line count, power of 2, >=2.
REQ-003 SHALL have parameter WordsPerLine, default 4: instructions per line, power of 2, >=2.
REQ-004 SHALL have parameter NopIns, default 32'h00000013: instruction driven when no hit.
REQ-005 SHALL provide ports:
  - clock  in  1  sole clock, rising edge.
  - reset  in  1  synchronous, active-high reset.
  - ProgAddr  in  dataW  PC fetch address.
  - Flush  in  1  invalidate all lines (fence.i).
  - OutputIns  out  dataW  instruction to decoder.
  - InsValid  out  1  OutputIns is a genuine cached instruction.
  - InsCacheStall  out  1  PC must hold.
  - Misaligned  out  1  ProgAddr[1:0] != 0.
  - MemReq  out  1  refill word request.
  - MemAddr  out  dataW  refill word address.
  - MemAck  in  1  MemData valid for current request.
  - MemData  in  dataW  refill instruction word.
  - HitCount  out  32  saturating hit counter.
  - MissCount  out  32  saturating miss counter.

Function
REQ-006 SHALL split ProgAddr as: bits [1:0] byte; next log2(WordsPerLine) bits word; next log2(Lines) bits index; remaining upper bits tag.
REQ-007 SHALL be direct-mapped, with one valid bit and one tag per line.
REQ-008 SHALL use FSM states IDLE and FILL.
REQ-009 In IDLE, hit = valid[index] && tag match && !Misaligned; hit is combinational, same cycle as ProgAddr.
REQ-010 On a hit, SHALL drive: OutputIns = stored word; InsValid=1; InsCacheStall=0.
REQ-011 On a miss in IDLE, SHALL drive InsCacheStall=1, InsValid=0, OutputIns=NopIns in that same cycle.
REQ-012 On that miss, SHALL at the next edge: latch line base (ProgAddr with word and byte bits zeroed) and tag; clear fill counter; enter FILL.
REQ-013 In FILL: MemReq=1; MemAddr = base + 4*counter; InsCacheStall=1; InsValid=0; OutputIns=NopIns.
REQ-014 In FILL, on MemAck, SHALL write MemData into word[counter] of the latched index and increment the counter.
REQ-015 On MemAck with counter == WordsPerLine-1, SHALL write the tag, set valid, and return to IDLE.
REQ-016 MemReq SHALL hold with a stable MemAddr until acked; any ack delay, including zero-wait, is legal.
REQ-017 Changes to ProgAddr during FILL SHALL be ignored; the lookup re-evaluates in IDLE.
REQ-018 With MemAck high every cycle: miss at cycle 0, FILL cycles 1..WordsPerLine, hit at cycle WordsPerLine+1.
REQ-019 MemAck outside FILL SHALL be ignored.
REQ-020 Misaligned SHALL assert combinationally; InsValid=0 and InsCacheStall=0 while it is set.
REQ-021 A misaligned address SHALL NOT start a fill and SHALL NOT count as a miss.
REQ-022 Flush in IDLE SHALL clear all valid bits at the next edge; the lookup in that same cycle still uses the old valid bits.
REQ-023 Flush in FILL SHALL set a pending flag; at fill completion, all valid bits including the new line SHALL clear and the flag SHALL clear.
REQ-024 Replacement SHALL overwrite the indexed line unconditionally.
REQ-025 HitCount SHALL increment once per IDLE hit cycle; MissCount once per IDLE->FILL transition; both saturate at 32'hFFFFFFFF.

Reset
REQ-026 SHALL put, on a reset edge: all valid bits 0, state IDLE, counter 0, flush-pending 0, HitCount 0, MissCount 0.
REQ-027 Output values during and after reset: MemReq=0; InsValid=0; OutputIns=NopIns; InsCacheStall=1 for any aligned ProgAddr.
REQ-028 Reset SHALL abort a FILL; the partially filled line SHALL remain invalid.
REQ-029 Data and tag arrays need no reset.

Verification
REQ-030 Reset, ProgAddr=0x0, MemAck tied 1, MemData=address:
  - MemAddr 0x0,0x4,0x8,0xC in cycles 1-4;
  - cycle 5: InsValid=1, OutputIns=0x0;
  - MissCount=1.
REQ-031 After REQ-030, ProgAddr steps 0x4,0x8,0xC:
  - each cycle hits, OutputIns=0x4,0x8,0xC, InsCacheStall=0;
  - HitCount increments each cycle; MemReq stays 0.
REQ-032 Conflict: fill 0x0, then ProgAddr=0x80 (same index, defaults), then 0x0:
  - two further misses; MissCount=3.
REQ-033 MemAck asserted every third cycle during a fill:
  - MemAddr holds per word; fill takes 12 FILL cycles;
  - stored data correct.
REQ-034 Flush asserted in FILL cycle 2:
  - line completes, then all valid=0;
  - a re-read of the same address misses again.
REQ-035 ProgAddr=0x6:
  - Misaligned=1, InsValid=0, InsCacheStall=0, MemReq=0, counters unchanged.
  Reset in FILL cycle 2:
  - MemReq=0 next cycle; subsequent read of that line misses.
